// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file writeback constants and source encoding
package rf_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_LSU = 1'b1
   } wb_src_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; on contention the source not granted last wins
module rr_arb2
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   wb_src_t last_grant_q;

   always_comb begin
      gnt_o = 2'b00;
      if (req_i[0] && (!req_i[1] || last_grant_q == WB_LSU))
         gnt_o[0] = 1'b1;
      else if (req_i[1])
         gnt_o[1] = 1'b1;
   end

   // Reset to LSU so that the ALU wins the first contest
   always_ff @(posedge clk) begin
      if (rst)
         last_grant_q <= WB_LSU;
      else if (gnt_o[0])
         last_grant_q <= WB_ALU;
      else if (gnt_o[1])
         last_grant_q <= WB_LSU;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write port arbiter (ALU/LSU) with pending-load scoreboard and decode stall
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              lsu_ready,
   input  logic              lsu_issue,
   input  logic [ADDR_W-1:0] lsu_issue_rd,
   input  logic [ADDR_W-1:0] id_rs1,
   input  logic [ADDR_W-1:0] id_rs2,
   input  logic [ADDR_W-1:0] id_rd,
   output logic              stall,
   output logic              reg_write,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] write_data
);

   localparam int NREG = 2 ** ADDR_W;

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic [ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              reg_write_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] write_data_q;
   logic [NREG-1:0]   pend_q;
   logic [NREG-1:0]   pend_d;
   logic              pend_hit;
   logic              wb_hit;

   assign req = {lsu_valid & ~rst, alu_valid & ~rst};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (req),
      .gnt_o (gnt)
   );

   assign alu_ready = gnt[0];
   assign lsu_ready = gnt[1];
   assign wb_rd     = gnt[1] ? lsu_rd   : alu_rd;
   assign wb_data   = gnt[1] ? lsu_data : alu_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
         write_data_q <= '0;
      end else begin
         reg_write_q <= (|gnt) && (wb_rd != '0);
         if (|gnt) begin
            rd_q         <= wb_rd;
            write_data_q <= wb_data;
         end
      end
   end

   // A new issue overrides a completing load to the same register
   always_comb begin
      pend_d = pend_q;
      if (lsu_ready)
         pend_d[lsu_rd] = 1'b0;
      if (lsu_issue && lsu_issue_rd != '0)
         pend_d[lsu_issue_rd] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         pend_q <= '0;
      else
         pend_q <= pend_d;
   end

   assign pend_hit = (id_rs1 != '0 && pend_q[id_rs1])
                   | (id_rs2 != '0 && pend_q[id_rs2])
                   | (id_rd  != '0 && pend_q[id_rd]);
   // The registered write is not yet visible to register-file reads
   assign wb_hit   = reg_write_q && (rd_q != '0) && (rd_q == id_rs1 || rd_q == id_rs2);
   assign stall    = ~rst & (pend_hit | wb_hit);

   assign reg_write  = reg_write_q;
   assign rd         = rd_q;
   assign write_data = write_data_q;

   a_no_reissue : assert property (@(posedge clk) disable iff (rst)
      (lsu_issue && lsu_issue_rd != '0) |-> !pend_q[lsu_issue_rd]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized and directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, lsu_valid, lsu_issue;
   logic [4:0]  alu_rd, lsu_rd, lsu_issue_rd, id_rs1, id_rs2, id_rd;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready, stall, reg_write;
   logic [4:0]  rd;
   logic [31:0] write_data;

   int total = 0;
   int bad   = 0;

   // reference model: architectural view of the write port and pending loads
   bit          m_last_lsu;
   logic [31:0] m_pend;
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_wd;
   bit          exp_ga, exp_gl, exp_stall;

   int cont_rd [4] = '{4, 5, 4, 5};

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .alu_ready    (alu_ready),
      .lsu_valid    (lsu_valid),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_ready    (lsu_ready),
      .lsu_issue    (lsu_issue),
      .lsu_issue_rd (lsu_issue_rd),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .stall        (stall),
      .reg_write    (reg_write),
      .rd           (rd),
      .write_data   (write_data)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last_lsu = 1'b1;
      m_pend     = '0;
      m_we       = 1'b0;
      m_rd       = '0;
      m_wd       = '0;
   endtask

   // compare process: let inputs settle, derive expected outputs, compare all
   task automatic settle();
      #1;
      exp_ga = 1'b0;
      exp_gl = 1'b0;
      if (!rst) begin
         if (alu_valid && lsu_valid) begin
            if (m_last_lsu) exp_ga = 1'b1;
            else            exp_gl = 1'b1;
         end else if (alu_valid) exp_ga = 1'b1;
         else if (lsu_valid)     exp_gl = 1'b1;
      end
      exp_stall = !rst && ((id_rs1 != 0 && m_pend[id_rs1]) || (id_rs2 != 0 && m_pend[id_rs2]) ||
                           (id_rd != 0 && m_pend[id_rd]) ||
                           (m_we && (m_rd == id_rs1 || m_rd == id_rs2)));
      chk("m_alu_ready",  {31'd0, alu_ready}, {31'd0, exp_ga});
      chk("m_lsu_ready",  {31'd0, lsu_ready}, {31'd0, exp_gl});
      chk("m_stall",      {31'd0, stall},     {31'd0, exp_stall});
      chk("m_reg_write",  {31'd0, reg_write}, {31'd0, m_we});
      chk("m_rd",         {27'd0, rd},        {27'd0, m_rd});
      chk("m_write_data", write_data,         m_wd);
   endtask

   task automatic tick();
      if (rst) begin
         model_reset();
      end else begin
         if (exp_ga) begin
            m_we = (alu_rd != 0); m_rd = alu_rd; m_wd = alu_data; m_last_lsu = 1'b0;
         end else if (exp_gl) begin
            m_we = (lsu_rd != 0); m_rd = lsu_rd; m_wd = lsu_data; m_last_lsu = 1'b1;
         end else begin
            m_we = 1'b0;
         end
         if (exp_gl) m_pend[lsu_rd] = 1'b0;
         if (lsu_issue && lsu_issue_rd != 0) m_pend[lsu_issue_rd] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   initial begin
      rst = 1'b1; alu_valid = 0; lsu_valid = 0; lsu_issue = 0;
      alu_rd = 0; lsu_rd = 0; lsu_issue_rd = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      alu_data = 0; lsu_data = 0;
      @(posedge clk);
      @(negedge clk);
      model_reset();

      // reset state, requests ignored while in reset
      alu_valid = 1; lsu_valid = 1; alu_rd = 1; lsu_rd = 2;
      settle();
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
      chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      tick();
      rst = 0; alu_valid = 0; lsu_valid = 0;

      // ALU only
      alu_valid = 1; alu_rd = 3; alu_data = 32'hA5;
      settle();
      chk("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      alu_valid = 0;
      settle();
      chk("t1_reg_write", {31'd0, reg_write}, 32'd1);
      chk("t1_rd", {27'd0, rd}, 32'd3);
      chk("t1_wdata", write_data, 32'hA5);
      tick();
      settle();
      chk("t1_reg_write_off", {31'd0, reg_write}, 32'd0);
      tick();

      // lone LSU grant so the ALU wins the next contest
      lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h55;
      step();

      // contention
      alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t2_alu_ready", {31'd0, alu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("t2_lsu_ready", {31'd0, lsu_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
         if (i > 0) chk("t2_rd", {27'd0, rd}, cont_rd[i-1]);
         tick();
      end
      alu_valid = 0; lsu_valid = 0;
      settle();
      chk("t2_rd_last", {27'd0, rd}, cont_rd[3]);
      tick();

      // load hazard
      lsu_issue = 1; lsu_issue_rd = 7;
      step();
      lsu_issue = 0; id_rs1 = 7;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("t3_stall_pend", {31'd0, stall}, 32'd1);
         tick();
      end
      lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
      settle();
      chk("t3_lsu_ready", {31'd0, lsu_ready}, 32'd1);
      chk("t3_stall_xfer", {31'd0, stall}, 32'd1);
      tick();
      lsu_valid = 0;
      settle();
      chk("t3_stall_wb", {31'd0, stall}, 32'd1);
      chk("t3_rd", {27'd0, rd}, 32'd7);
      tick();
      settle();
      chk("t3_stall_clear", {31'd0, stall}, 32'd0);
      tick();
      id_rs1 = 0;

      // x0 handling
      alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
      settle();
      chk("t4_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      alu_valid = 0; lsu_issue = 1; lsu_issue_rd = 0;
      settle();
      chk("t4_reg_write", {31'd0, reg_write}, 32'd0);
      chk("t4_stall_x0", {31'd0, stall}, 32'd0);
      tick();
      lsu_issue = 0;
      settle();
      chk("t4_stall_x0_after", {31'd0, stall}, 32'd0);
      tick();

      // set/clear collision on the same register
      lsu_issue = 1; lsu_issue_rd = 9; lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
      settle();
      chk("t5_lsu_ready", {31'd0, lsu_ready}, 32'd1);
      tick();
      lsu_issue = 0; lsu_valid = 0; id_rs1 = 9;
      step();
      settle();
      chk("t5_pend_kept", {31'd0, stall}, 32'd1);
      tick();
      lsu_valid = 1;
      step();
      lsu_valid = 0;
      step();
      id_rs1 = 0;

      // reset in the cycle after a grant
      alu_valid = 1; alu_rd = 2; alu_data = 32'h22; lsu_issue = 1; lsu_issue_rd = 10;
      step();
      alu_valid = 0; lsu_issue = 0; rst = 1;
      settle();
      chk("t6_reg_write_pre", {31'd0, reg_write}, 32'd1);
      tick();
      rst = 0; id_rs1 = 10;
      alu_valid = 1; alu_rd = 4; lsu_valid = 1; lsu_rd = 5;
      settle();
      chk("t6_reg_write", {31'd0, reg_write}, 32'd0);
      chk("t6_stall", {31'd0, stall}, 32'd0);
      chk("t6_alu_wins", {31'd0, alu_ready}, 32'd1);
      tick();
      alu_valid = 0; lsu_valid = 0; id_rs1 = 0;
      step();

      // randomized traffic, requests held until transferred
      for (int c = 0; c < 3000; c++) begin
         if (!alu_valid || exp_ga) begin
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
         end
         if (!lsu_valid || exp_gl) begin
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_rd    = 5'($urandom_range(0, 7));
            lsu_data  = $urandom;
         end
         lsu_issue_rd = 5'($urandom_range(0, 7));
         lsu_issue    = ($urandom_range(0, 3) == 0) && (lsu_issue_rd == 0 || !m_pend[lsu_issue_rd]);
         id_rs1 = 5'($urandom_range(0, 7));
         id_rs2 = 5'($urandom_range(0, 7));
         id_rd  = 5'($urandom_range(0, 7));
         rst    = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources: the ALU (src0) and the load/store unit (src1, multi-cycle loads).
- Round-robin arbitration with valid/ready handshakes and a registered write port.
- Holds a pending-load scoreboard and drives a hazard `stall` to the decode stage, so no read sees stale data while a load or a registered write is still in flight.

Parameters:
- DATA_W, 32, width of writeback data.
- ADDR_W, 5, register index width; the scoreboard holds 2**ADDR_W bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  load writeback request.
- lsu_rd  in  ADDR_W  load destination register.
- lsu_data  in  DATA_W  load data.
- lsu_ready  out  1  load request accepted this cycle.
- lsu_issue  in  1  load issued to memory this cycle.
- lsu_issue_rd  in  ADDR_W  destination register of the issued load.
- id_rs1  in  ADDR_W  decode-stage source register 1.
- id_rs2  in  ADDR_W  decode-stage source register 2.
- id_rd  in  ADDR_W  decode-stage destination register.
- stall  out  1  decode must hold this cycle.
- reg_write  out  1  register file write enable (registered).
- rd  out  ADDR_W  register file write index (registered).
- write_data  out  DATA_W  register file write data (registered).

Behaviour:
- **Handshake**
  - A transfer occurs when `x_valid & x_ready`.
  - `ready` is combinational and may depend on `valid`. `valid` must not depend on `ready`.
  - Once asserted, `valid`, `rd` and `data` must be held until the transfer.
- **Arbitration**
  - Exactly one grant per cycle when any source is valid.
  - Single requester: it is granted.
  - Both requesters: grant the source not granted last.
  - The `last_grant` register updates on every grant. Reset value = LSU, so the ALU wins the first contest.
- **Write port**
  - On the grant edge: `reg_write <= (granted rd != 0)`, `rd <= granted rd`, `write_data <= granted data`.
  - With no grant: `reg_write <= 0`; `rd`/`write_data` hold their values.
  - Latency: data accepted in cycle N is driven in cycle N+1 and written to the register file at the end of N+1.
  - Throughput: 1 write per cycle.
  - An rd=0 request is accepted (ready=1) but produces no write.
- **Scoreboard** `pend[2**ADDR_W-1:0]`
  - Set bit on `lsu_issue` when `lsu_issue_rd != 0`.
  - Clear bit on an LSU transfer to `lsu_rd`.
  - Same cycle set and clear of the same index: set wins.
  - `pend[0]` is always 0.
- **stall** (combinational) is the OR of:
  - `pend[id_rs1]`, `pend[id_rs2]`, `pend[id_rd]` (the id_rd term is the WAW guard), with index 0 masked;
  - `reg_write & (rd == id_rs1 | rd == id_rs2)` with rd != 0. This covers the cycle between grant and the register file update.
- **Issue rule:** decode never issues a load whose rd is pending; the `id_rd` stall term guarantees this. An `lsu_issue` to an already-pending rd is illegal and covered by an assertion.
- **Reset**
  - All outputs reset to: `reg_write=0`, `rd=0`, `write_data=0`, `alu_ready=0`, `lsu_ready=0`, `stall=0`.
  - Internal state resets to: `pend=0`, `last_grant=LSU`.
  - Reset mid-transfer discards any in-flight write. Requests asserted during rst are ignored (ready forced 0).

Decomposition:
- Shared package `rf_pkg`:
  - constants REG_ADDR_W=5, XLEN=32, NUM_REGS=32;
  - enum `wb_src_t {WB_ALU, WB_LSU}` for `last_grant`.
- Sub-module `rr_arb2`: two-way round-robin grant with `last_grant` state. Used once here and reusable for other two-requester arbiters.
- Scoreboard stays inline.

Test Plan:
1. ALU only: alu_valid=1, rd=3, data=0xA5 in cycle 0 → alu_ready=1 in cycle 0; reg_write=1, rd=3, write_data=0xA5 in cycle 1; reg_write=0 in cycle 2.
2. Contention: both valid for 4 cycles (ALU rd=4 / LSU rd=5) → grants ALU, LSU, ALU, LSU; rd outputs 4, 5, 4, 5 one cycle later; never two readys in one cycle.
3. Load hazard: lsu_issue rd=7, then id_rs1=7 → stall=1 until the LSU transfer to rd=7 and one further cycle (registered write); stall=0 after that.
4. x0 handling: ALU rd=0 data=0xFF → alu_ready=1, reg_write stays 0. lsu_issue rd=0 → pend unchanged, id_rs1=0 never stalls.
5. Set/clear collision: an LSU transfer to rd=9 in the same cycle as lsu_issue rd=9 → pend[9] remains 1.
6. Reset mid-operation: rst=1 in the cycle after a grant → reg_write=0 next cycle, pend all 0, and the next contest is won by the ALU.
